// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Shares one single-ported RAM between instruction fetch and data
//            ports; data has priority, fetch is protected from starvation, and
//            a watchdog aborts RAM accesses that never acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ack,
    output logic        bus_err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [WW-1:0] C_WD_LAST    = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           ihit_q, ihit_d;
    logic           dhit_q, dhit_d;
    logic [31:0]    iload_q, iload_d;
    logic [31:0]    dload_q, dload_d;
    logic           ramren_q, ramren_d;
    logic           ramwen_q, ramwen_d;
    logic [31:0]    ramaddr_q, ramaddr_d;
    logic [31:0]    ramstore_q, ramstore_d;
    logic           bus_err_q, bus_err_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [WW-1:0]  wd_q, wd_d;

    logic           w_fetch_elig;
    logic           w_data_elig;
    logic           w_done;

    // A port whose hit is showing is the old request still being held.
    assign w_fetch_elig = iREN & ~ihit_q;
    assign w_data_elig  = (dREN | dWEN) & ~dhit_q;
    assign w_done       = ram_ack | (wd_q == C_WD_LAST);

    always_comb begin
        state_d    = state_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        iload_d    = iload_q;
        dload_d    = dload_q;
        ramren_d   = ramren_q;
        ramwen_d   = ramwen_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        bus_err_d  = bus_err_q;
        starve_d   = starve_q;
        wd_d       = wd_q;

        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (w_data_elig && (!w_fetch_elig || (starve_q < C_STARVE_MAX))) begin
                    state_d    = S_DACC;
                    ramren_d   = ~dWEN;
                    ramwen_d   = dWEN;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    if (!w_fetch_elig) begin
                        starve_d = '0;
                    end else if (starve_q != C_STARVE_MAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (w_fetch_elig) begin
                    state_d   = S_IACC;
                    ramren_d  = 1'b1;
                    ramwen_d  = 1'b0;
                    ramaddr_d = iaddr;
                    starve_d  = '0;
                end
            end
            S_IACC, S_DACC: begin
                if (w_done) begin
                    state_d  = S_IDLE;
                    ramren_d = 1'b0;
                    ramwen_d = 1'b0;
                    wd_d     = '0;
                    if (!ram_ack) begin
                        bus_err_d = 1'b1;
                    end
                    // Hit only goes to a requester that is still asking.
                    if (state_q == S_IACC) begin
                        iload_d = ram_ack ? ramload : ERR_WORD;
                        ihit_d  = iREN;
                    end else begin
                        if (!ram_ack) begin
                            dload_d = ERR_WORD;
                        end else if (!ramwen_q) begin
                            dload_d = ramload;
                        end
                        dhit_d = dREN | dWEN;
                    end
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                ramren_d = 1'b0;
                ramwen_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            bus_err_q  <= 1'b0;
            starve_q   <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            bus_err_q  <= bus_err_d;
            starve_q   <= starve_d;
            wd_q       <= wd_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramren_q;
    assign ramWEN   = ramwen_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign bus_err  = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Directed and random stimulus for memory_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam int          TIMEOUT    = 64;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ack = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic        ihit, dhit, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT),
        .ERR_WORD   (ERR_WORD)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .ihit     (ihit),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dhit     (dhit),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ram_ack  (ram_ack),
        .bus_err  (bus_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding transaction plus expected pins.
    bit          m_busy, m_is_data, m_is_write;
    logic [31:0] m_addr, m_wdata;
    int          m_age, m_starve;
    logic        e_ihit, e_dhit, e_ren, e_wen, e_err;
    logic [31:0] e_iload, e_dload, e_addr, e_store;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_data = 0; m_is_write = 0; m_addr = '0; m_wdata = '0;
        m_age = 0; m_starve = 0;
        e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_err = 0;
        e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
    endtask

    task automatic model_edge();
        logic fe, de, nih, ndh;
        nih = 0; ndh = 0;
        if (m_busy) begin
            if (ram_ack || m_age == TIMEOUT - 1) begin
                if (m_is_data) begin
                    if (!ram_ack)         e_dload = ERR_WORD;
                    else if (!m_is_write) e_dload = ramload;
                    ndh = dREN | dWEN;
                end else begin
                    e_iload = ram_ack ? ramload : ERR_WORD;
                    nih = iREN;
                end
                if (!ram_ack) e_err = 1;
                m_busy = 0;
            end else begin
                m_age++;
            end
        end else begin
            fe = iREN && !e_ihit;
            de = (dREN || dWEN) && !e_dhit;
            if (de && (!fe || m_starve < STARVE_MAX)) begin
                m_busy = 1; m_is_data = 1; m_is_write = dWEN;
                m_addr = daddr; m_wdata = dstore; m_age = 0;
                m_starve = fe ? m_starve + 1 : 0;
            end else if (fe) begin
                m_busy = 1; m_is_data = 0; m_is_write = 0;
                m_addr = iaddr; m_age = 0; m_starve = 0;
            end
        end
        e_ihit = nih;
        e_dhit = ndh;
        e_ren  = m_busy && !m_is_write;
        e_wen  = m_busy && m_is_write;
        if (m_busy) e_addr = m_addr;
        if (m_busy && m_is_write) e_store = m_wdata;
    endtask

    task automatic compare_all();
        chk("ihit", ihit, e_ihit);
        chk("dhit", dhit, e_dhit);
        chk("iload", iload, e_iload);
        chk("dload", dload, e_dload);
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("bus_err", bus_err, e_err);
        if (e_ren || e_wen) chk("ramaddr", ramaddr, e_addr);
        if (e_wen) chk("ramstore", ramstore, e_store);
    endtask

    task automatic step();
        @(posedge CLK);
        if (RST) model_reset();
        else     model_edge();
        #1;
        compare_all();
    endtask

    task automatic new_data();
        dWEN   = ($urandom_range(0, 2) == 0);
        dREN   = dWEN ? 1'($urandom_range(0, 1)) : 1'b1;
        daddr  = $urandom;
        dstore = $urandom;
    endtask

    initial begin
        model_reset();
        // Reset state
        step();
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        step();
        RST = 1'b0;

        // Acknowledge while idle is ignored
        ram_ack = 1'b1; ramload = 32'h1234_5678;
        step();
        chk("idle_ack_ren", ramREN, 1'b0);
        ram_ack = 1'b0;
        step();

        // Single fetch, best-case latency
        iREN = 1'b1; iaddr = 32'h40;
        step();
        chk("t2_ramREN", ramREN, 1'b1);
        chk("t2_ramaddr", ramaddr, 32'h40);
        ram_ack = 1'b1; ramload = 32'h2408_0001; iaddr = 32'hFFFF_0000;
        step();
        chk("t2_ihit", ihit, 1'b1);
        chk("t2_iload", iload, 32'h2408_0001);
        iREN = 1'b0; ram_ack = 1'b0;
        step();
        chk("t2_no_regrant", ramREN, 1'b0);
        step();

        // Collision: data first, then fetch
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h100;
        step();
        chk("t3_data_first", ramaddr, 32'h100);
        ram_ack = 1'b1; ramload = 32'hA5A5_0100;
        step();
        chk("t3_dhit", dhit, 1'b1);
        chk("t3_dload", dload, 32'hA5A5_0100);
        dREN = 1'b0; ram_ack = 1'b0;
        step();
        chk("t3_fetch_next", ramaddr, 32'h200);
        ram_ack = 1'b1; ramload = 32'h0000_0200;
        step();
        chk("t3_ihit", ihit, 1'b1);
        iREN = 1'b0; ram_ack = 1'b0;
        step();

        // Starvation guard: data re-requests while fetch waits
        iREN = 1'b1; iaddr = 32'h300;
        for (int k = 0; k < 5; k++) begin
            dREN = 1'b1; daddr = 32'h400 + 32'(k * 4);
            step();
            if (k < 4) chk("t4_dgrant", ramaddr, 32'h400 + 32'(k * 4));
            else       chk("t4_fetch_wins", ramaddr, 32'h300);
            ram_ack = 1'b1; ramload = $urandom;
            if (k < 4) dREN = 1'b0;
            step();
            if (k < 4) chk("t4_dhit_dropped", dhit, 1'b0);
            else       chk("t4_ihit", ihit, 1'b1);
            ram_ack = 1'b0;
        end
        iREN = 1'b0;
        step();
        chk("t4_pending_data", ramaddr, 32'h410);
        ram_ack = 1'b1; ramload = 32'h0BAD_F00D;
        step();
        chk("t4_dhit", dhit, 1'b1);
        dREN = 1'b0; ram_ack = 1'b0;
        step();

        // Continuous contention
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h500; daddr = 32'h600;
        for (int c = 0; c < 30; c++) begin
            ram_ack = e_ren | e_wen; ramload = $urandom;
            step();
        end
        iREN = 1'b0; dREN = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ram_ack = e_ren | e_wen; ramload = $urandom;
            step();
        end
        ram_ack = 1'b0;
        step();

        // Write held four cycles
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        step();
        daddr = 32'hFFFF_FFFF; dstore = 32'h0;
        for (int c = 0; c < 4; c++) begin
            chk("t5_ramWEN", ramWEN, 1'b1);
            chk("t5_ramstore", ramstore, 32'hDEAD_BEEF);
            chk("t5_ramaddr", ramaddr, 32'h80);
            ram_ack = (c == 3);
            step();
        end
        chk("t5_dhit", dhit, 1'b1);
        chk("t5_wen_drop", ramWEN, 1'b0);
        dWEN = 1'b0; ram_ack = 1'b0;
        step();
        chk("t5_dhit_once", dhit, 1'b0);

        // Watchdog abort
        dREN = 1'b1; daddr = 32'h700;
        step();
        for (int c = 0; c < TIMEOUT - 1; c++) step();
        chk("t6_still_waiting", dhit, 1'b0);
        step();
        chk("t6_dhit", dhit, 1'b1);
        chk("t6_dload", dload, ERR_WORD);
        chk("t6_bus_err", bus_err, 1'b1);
        dREN = 1'b0;
        step();
        step();
        chk("t6_bus_err_sticky", bus_err, 1'b1);

        // Watchdog abort of a dropped request
        dREN = 1'b1; daddr = 32'h780;
        step();
        dREN = 1'b0;
        for (int c = 0; c < TIMEOUT; c++) step();
        chk("t6b_no_dhit", dhit, 1'b0);
        chk("t6b_strobe_off", ramREN, 1'b0);

        // Reset in the middle of a data access
        dREN = 1'b1; daddr = 32'h7C0;
        step();
        chk("t1_in_dacc", ramREN, 1'b1);
        RST = 1'b1; dREN = 1'b0; ram_ack = 1'b1;
        #1;
        chk("t1_ramREN", ramREN, 1'b0);
        chk("t1_ramaddr", ramaddr, 32'h0);
        chk("t1_bus_err", bus_err, 1'b0);
        chk("t1_dload", dload, 32'h0);
        model_reset();
        step();
        RST = 1'b0; ram_ack = 1'b0;
        step();
        chk("t1_no_dhit", dhit, 1'b0);
        step();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            if (iREN && e_ihit) begin
                iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
            end else if (!iREN) begin
                if ($urandom_range(0, 3) == 0) begin iREN = 1'b1; iaddr = $urandom; end
            end else if ($urandom_range(0, 39) == 0) begin
                iREN = 1'b0;
            end
            if ((dREN || dWEN) && e_dhit) begin
                if ($urandom_range(0, 1) == 1) new_data();
                else begin dREN = 1'b0; dWEN = 1'b0; end
            end else if (!(dREN || dWEN)) begin
                if ($urandom_range(0, 3) == 0) new_data();
            end else if ($urandom_range(0, 39) == 0) begin
                dREN = 1'b0; dWEN = 1'b0;
            end
            if (m_busy && m_is_data)  begin daddr = $urandom; dstore = $urandom; end
            if (m_busy && !m_is_data) iaddr = $urandom;
            ram_ack = (e_ren || e_wen) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            ramload = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
